// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with majority voting, parity/framing/overrun errors and a show-ahead FIFO
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          brclk,
    input  logic                          reset,
    input  logic                          uart_rx,
    input  logic                          rx_ready,
    input  logic                          clr_err,
    output logic                          rx_valid,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_overrun,
    output logic                          rx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int EW = DATA_BITS + 2;
    localparam int M  = OVERSAMPLE / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t                st;
    logic                  sy1, rxs, sa, sb, perr, ferr, push;
    logic [CW-1:0]         cnt;
    logic [3:0]            bn;
    logic [DATA_BITS-1:0]  sh;
    logic [EW-1:0]         ent, head_q, nh;
    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         rp, wp;
    logic                  maj, wrap, dec, full, wr, rd;

    assign maj  = (sa & sb) | (sa & rxs) | (sb & rxs);
    assign wrap = cnt == CW'(OVERSAMPLE - 1);
    assign dec  = cnt == CW'(M + 1);
    assign rx_busy = st != IDLE;

    always_ff @(posedge brclk or negedge reset) begin
        if (!reset) begin
            sy1  <= 1'b1;
            rxs  <= 1'b1;
            st   <= IDLE;
            cnt  <= '0;
            bn   <= '0;
            sa   <= 1'b1;
            sb   <= 1'b1;
            sh   <= '0;
            perr <= 1'b0;
            ferr <= 1'b0;
            push <= 1'b0;
            ent  <= '0;
        end else begin
            sy1  <= uart_rx;
            rxs  <= sy1;
            push <= 1'b0;
            cnt  <= wrap ? '0 : cnt + 1'b1;
            if (cnt == CW'(M - 1)) sa <= rxs;
            if (cnt == CW'(M)) sb <= rxs;
            case (st)
                IDLE: begin
                    cnt  <= rxs ? '0 : CW'(1);
                    bn   <= '0;
                    perr <= 1'b0;
                    ferr <= 1'b0;
                    if (!rxs) st <= START;
                end
                START: begin
                    if (dec && maj) begin
                        st  <= IDLE;
                        cnt <= '0;
                    end else if (wrap) st <= DATA;
                end
                DATA: begin
                    if (dec) sh <= {maj, sh[DATA_BITS-1:1]};
                    if (wrap) begin
                        bn <= bn + 1'b1;
                        if (bn == 4'(DATA_BITS - 1)) begin
                            bn <= '0;
                            st <= PARITY_EN != 0 ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (dec) perr <= maj != (^sh ^ (PARITY_ODD != 0));
                    if (wrap) st <= STOP;
                end
                STOP: begin
                    if (dec) begin
                        ferr <= ferr | ~maj;
                        if (bn == 4'(STOP_BITS - 1)) begin
                            push <= 1'b1;
                            ent  <= {ferr | ~maj, perr, sh};
                            st   <= maj ? IDLE : WAIT_HIGH;
                            cnt  <= '0;
                            bn   <= '0;
                        end
                    end else if (wrap) bn <= bn + 1'b1;
                end
                WAIT_HIGH: begin
                    cnt <= '0;
                    if (rxs) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign rx_valid = fifo_count != '0;
    assign full     = fifo_count == NW'(FIFO_DEPTH);
    assign rd       = rx_valid && rx_ready;
    assign wr       = push && (!full || rd);
    assign nh       = (fifo_count == NW'(rd)) ? ent : mem[rd ? rp + 1'b1 : rp];
    assign {rx_frame_err, rx_parity_err, rx_data} = head_q;

    always_ff @(posedge brclk) if (wr) mem[wp] <= ent;

    // head_q mirrors the next head entry so outputs hold their last value when empty
    always_ff @(posedge brclk or negedge reset) begin
        if (!reset) begin
            rp         <= '0;
            wp         <= '0;
            fifo_count <= '0;
            rx_overrun <= 1'b0;
            head_q     <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            fifo_count <= fifo_count + NW'(wr) - NW'(rd);
            rx_overrun <= (push && full && !rd) ? 1'b1 : (clr_err ? 1'b0 : rx_overrun);
            if (wr || (rd && fifo_count > NW'(1))) head_q <= nh;
        end
    end
endmodule
